// File: rtl/cfg_initiator.sv
// cfg_initiator: issues one register read/write at a time onto the
// configuration ring as a head+tail control packet and, for reads, waits
// for the matching read-response head word.
//   clk, rst                      clock, async active-high reset
//   req_*                         host request (accepted on req_valid & req_ready)
//   resp_valid/resp_rdata/resp_err completion pulse, read data, timeout flag
//   cout_data/cout_data_wr        outgoing ring word, gated by cin_ready
//   cin_data/cin_data_wr          returning ring word
//   stray_cnt                     saturating count of unconsumed returned heads
module cfg_initiator #(
  parameter logic [7:0]  SMID    = 8'd1,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_wr,
  input  logic [7:0]   req_dmid,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         resp_err,
  output logic [133:0] cout_data,
  output logic         cout_data_wr,
  input  logic         cin_ready,
  input  logic [133:0] cin_data,
  input  logic         cin_data_wr,
  output logic [15:0]  stray_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_TAIL,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  localparam logic [133:0] TAIL_WORD = {2'b10, 132'd0};

  state_t        state;
  logic [11:0]   seq_cnt;
  logic [11:0]   pkt_seq;
  logic          pkt_wr;
  logic [7:0]    pkt_dmid;
  logic [31:0]   pkt_addr;
  logic [31:0]   pkt_wdata;
  logic [15:0]   timer;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          cin_head;
  logic          rsp_match;
  logic [133:0]  head_word;

  always_comb begin
    cin_head  = cin_data_wr && (cin_data[133:132] == 2'b01);
    rsp_match = cin_head &&
                (cin_data[127:124] == 4'b1011) &&
                (cin_data[103:96]  == SMID) &&
                (cin_data[123:112] == pkt_seq) &&
                (state == S_WAIT_RSP);
    head_word = {2'b01, 4'h0, (pkt_wr ? 4'b0010 : 4'b0001), pkt_seq, SMID,
                 pkt_dmid, pkt_addr, 32'h0, pkt_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      seq_cnt      <= '0;
      pkt_seq      <= '0;
      pkt_wr       <= 1'b0;
      pkt_dmid     <= '0;
      pkt_addr     <= '0;
      pkt_wdata    <= '0;
      timer        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      cout_data    <= '0;
      cout_data_wr <= 1'b0;
      stray_cnt    <= '0;
    end else begin
      cout_data_wr <= 1'b0;
      cout_data    <= '0;
      resp_valid   <= 1'b0;

      if (cin_head && !rsp_match && (stray_cnt != '1))
        stray_cnt <= stray_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            pkt_seq   <= seq_cnt;
            seq_cnt   <= seq_cnt + 12'd1;
            pkt_wr    <= req_wr;
            pkt_dmid  <= req_dmid;
            pkt_addr  <= req_addr;
            pkt_wdata <= req_wr ? req_wdata : 32'h0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            state     <= S_HEAD;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_HEAD: begin
          if (cin_ready) begin
            cout_data    <= head_word;
            cout_data_wr <= 1'b1;
            state        <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (cin_ready) begin
            cout_data    <= TAIL_WORD;
            cout_data_wr <= 1'b1;
            timer        <= '0;
            state        <= pkt_wr ? S_DONE : S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_match) begin
            rdata_q <= cin_data[31:0];
            err_q   <= 1'b0;
            state   <= S_DONE;
          end else if (timer == (TIMEOUT - 16'd1)) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_DONE: begin
          resp_valid <= 1'b1;
          resp_rdata <= rdata_q;
          resp_err   <= err_q;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
